// File: rtl/mem_fu.sv
// mem_fu: memory functional unit with one op in flight, store commit gating and CDB writeback.
// Optional misaligned-access trap enabled by defining MEM_FU_MISALIGN_CHK_EN.
package mem_fu_pkg;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    typedef struct packed {
        logic [31:0] insn;
        logic [63:0] order;
    } rvfi_t;

    typedef struct packed {
        logic             valid;
        logic [2:0]       mem_op;
        logic             ls;
        logic [XLEN-1:0]  rs1_v;
        logic [XLEN-1:0]  rs2_v;
        logic [XLEN-1:0]  offset;
        logic [TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]  pc;
        rvfi_t            rvfi;
    } fu_pkt_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]  data;
    } cdb_t;
endpackage

module mem_fu
    import mem_fu_pkg::*;
#(
    parameter int DATA_W    = XLEN,
    parameter int ROB_TAG_W = TAG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  fu_pkt_t              mem_pkt,
    output logic                 backpressure,
    input  logic                 rob_head_valid,
    input  logic [ROB_TAG_W-1:0] rob_head_tag,
    output logic [DATA_W-1:0]    dmem_addr,
    output logic [3:0]           dmem_rmask,
    output logic [3:0]           dmem_wmask,
    output logic [DATA_W-1:0]    dmem_wdata,
    input  logic [DATA_W-1:0]    dmem_rdata,
    input  logic                 dmem_resp,
    output cdb_t                 cdb_out,
    input  logic                 cdb_grant
`ifdef MEM_FU_MISALIGN_CHK_EN
    ,
    output logic                 mem_misalign
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_COMMIT,
        REQ,
        DRAIN,
        WB
    } state_e;

    state_e               r_state;
    state_e               w_state_nxt;
    logic [DATA_W-1:0]    r_ea;
    logic [2:0]           r_op;
    logic                 r_ls;
    logic [DATA_W-1:0]    r_wsrc;
    logic [ROB_TAG_W-1:0] r_tag;
    logic [DATA_W-1:0]    r_result;

    logic [DATA_W-1:0]    w_ea_in;
    logic                 w_accept;
    logic                 w_head_hit;
    logic                 w_skip_in;
    logic                 w_skip;
    logic [3:0]           w_base;
    logic [3:0]           w_mask;
    logic [DATA_W-1:0]    w_lane;
    logic [DATA_W-1:0]    w_load_val;
    logic                 w_unused;

    assign w_ea_in    = mem_pkt.rs1_v + mem_pkt.offset;
    assign w_accept   = (r_state == IDLE) && mem_pkt.valid && !flush;
    assign w_head_hit = rob_head_valid && (rob_head_tag == r_tag);
    assign w_unused   = ^{mem_pkt.pc, mem_pkt.rvfi};

`ifdef MEM_FU_MISALIGN_CHK_EN
    function automatic logic f_misaligned(input logic [2:0] op,
                                          input logic [1:0] lo);
        return ((op[1:0] == 2'b01) && lo[0]) ||
               ((op[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

    assign w_skip_in = f_misaligned(mem_pkt.mem_op, w_ea_in[1:0]);
    assign w_skip    = f_misaligned(r_op, r_ea[1:0]);
    assign mem_misalign = (r_state == WB) && w_skip;
`else
    assign w_skip_in = 1'b0;
    assign w_skip    = 1'b0;
`endif

    // Byte-lane enables; out-of-range lanes fall off the 4-bit result.
    always_comb begin
        w_base = 4'b0000;
        unique case (1'b1)
            (r_op[1:0] == 2'b00): w_base = 4'b0001;
            (r_op[1:0] == 2'b01): w_base = 4'b0011;
            (r_op[1:0] == 2'b10): w_base = 4'b1111;
            default:              w_base = 4'b0000;
        endcase
    end

    assign w_mask = w_base << r_ea[1:0];
    assign w_lane = dmem_rdata >> {r_ea[1:0], 3'b000};

    always_comb begin
        w_load_val = w_lane;
        unique case (1'b1)
            (r_op == 3'b000):
                w_load_val = {{(DATA_W-8){w_lane[7]}}, w_lane[7:0]};
            (r_op == 3'b001):
                w_load_val = {{(DATA_W-16){w_lane[15]}}, w_lane[15:0]};
            (r_op == 3'b100):
                w_load_val = {{(DATA_W-8){1'b0}}, w_lane[7:0]};
            (r_op == 3'b101):
                w_load_val = {{(DATA_W-16){1'b0}}, w_lane[15:0]};
            default:
                w_load_val = w_lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (mem_pkt.ls)     w_state_nxt = WAIT_COMMIT;
                    else if (w_skip_in) w_state_nxt = WB;
                    else                w_state_nxt = REQ;
                end
            end
            WAIT_COMMIT: begin
                if (flush)           w_state_nxt = IDLE;
                else if (w_head_hit) w_state_nxt = w_skip ? WB : REQ;
            end
            REQ: begin
                // A flushed request still owns the port until memory answers.
                if (flush)          w_state_nxt = dmem_resp ? IDLE : DRAIN;
                else if (dmem_resp) w_state_nxt = WB;
            end
            DRAIN: begin
                if (dmem_resp) w_state_nxt = IDLE;
            end
            WB: begin
                if (flush || cdb_grant) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        backpressure = (r_state != IDLE);
        dmem_addr    = '0;
        dmem_rmask   = 4'b0000;
        dmem_wmask   = 4'b0000;
        dmem_wdata   = '0;
        cdb_out      = '0;
        unique case (r_state)
            REQ, DRAIN: begin
                dmem_addr = {r_ea[DATA_W-1:2], 2'b00};
                if (r_ls) begin
                    dmem_wmask = w_mask;
                    dmem_wdata = r_wsrc << {r_ea[1:0], 3'b000};
                end else begin
                    dmem_rmask = w_mask;
                end
            end
            WB: begin
                cdb_out.valid   = 1'b1;
                cdb_out.rob_tag = r_tag;
                cdb_out.data    = r_result;
            end
            default: ;
        endcase
    end

    // Result is cleared on accept so stores and trapped ops report zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ea     <= '0;
            r_op     <= '0;
            r_ls     <= 1'b0;
            r_wsrc   <= '0;
            r_tag    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_ea     <= w_ea_in;
            r_op     <= mem_pkt.mem_op;
            r_ls     <= mem_pkt.ls;
            r_wsrc   <= mem_pkt.rs2_v;
            r_tag    <= mem_pkt.rob_tag;
            r_result <= '0;
        end else if ((r_state == REQ) && dmem_resp && !r_ls) begin
            r_result <= w_load_val;
        end
    end

endmodule

// File: doc/mem_fu.md
# mem_fu

Memory functional unit directly downstream of the in-order memory issue queue. It consumes one `fu_pkt_t` at a time and forms the effective address. It drives a single-ported data-memory request and returns load data, or store completion, to the ROB over a CDB result port. One operation is in flight at a time; `backpressure` stalls the issue queue head while the unit is busy.

## Interface
- `DATA_W`, 32: data and address width.
- `ROB_TAG_W`, 5: ROB tag width; must match `fu_pkt_t.rob_tag`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset; 0 = reset.
- `flush` in 1: squash; synchronous, evaluated at the clock edge.
- `mem_pkt` in `fu_pkt_t`: issued op. Fields used: valid, mem_op, ls, rs1_v, rs2_v, offset, rob_tag, pc, rvfi.
- `backpressure` out 1: 1 = unit cannot accept `mem_pkt` this cycle.
- `rob_head_valid` in 1: ROB head entry is valid.
- `rob_head_tag` in ROB_TAG_W: tag of the ROB head.
- `dmem_addr` out DATA_W: word-aligned address (low 2 bits 0).
- `dmem_rmask` out 4: byte read enables.
- `dmem_wmask` out 4: byte write enables.
- `dmem_wdata` out DATA_W: write data, lane-shifted.
- `dmem_rdata` in DATA_W: read data, valid with `dmem_resp`.
- `dmem_resp` in 1: single-cycle completion pulse.
- `cdb_out` out `cdb_t`: result broadcast (valid, rob_tag, data).
- `cdb_grant` in 1: CDB arbiter accepted `cdb_out` this cycle.
- `mem_misalign` out 1: qualifies `cdb_out`. Exists only with MEM_FU_MISALIGN_CHK_EN.

## Operation
- FSM states: IDLE, WAIT_COMMIT, REQ, DRAIN, WB.
- `backpressure` = (state != IDLE), combinational from state only.
- IDLE:
  - If `mem_pkt.valid`, latch the packet and compute ea = rs1_v + offset, modulo 2^DATA_W.
  - Load → REQ.
  - Store → WAIT_COMMIT.
- WAIT_COMMIT:
  - → REQ when `rob_head_valid` and `rob_head_tag` == latched tag.
  - Checked the same cycle as entry is not possible; earliest exit is the cycle after accept.
- REQ:
  - `dmem_addr` = {ea[DATA_W-1:2], 2'b00}.
  - Load masks: byte (000/100) 4'b0001<<ea[1:0]; half (001/101) 4'b0011<<ea[1:0]; word (010) 4'b1111.
  - Store masks use the same encoding on `dmem_wmask`.
  - Store data: `dmem_wdata` = rs2_v << (8*ea[1:0]).
  - Masks and data are held stable until `dmem_resp`.
  - On `dmem_resp` → WB. For loads, capture the extracted lane: 000 sign-extend byte, 001 sign-extend half, 100/101 zero-extend, 010 word.
- WB:
  - `cdb_out.valid`=1, rob_tag = latched tag.
  - data = load result, or 0 for stores.
  - → IDLE on `cdb_grant`.
- All other states drive masks = 0 and `cdb_out` = '0.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, `backpressure`=0, all `dmem_*` outputs 0, `cdb_out`='0, `mem_misalign`=0.
- Load, zero-wait memory:
  - Accept at cycle N.
  - Request at N+1; resp at N+1.
  - `cdb_out.valid` at N+2.
  - IDLE at N+3 if granted at N+2.
- Latency grows by one cycle per memory wait cycle and per ungranted WB cycle.
- Store: REQ begins the cycle after the head match is seen in WAIT_COMMIT.
- `flush` handling:
  - IDLE/WAIT_COMMIT/WB → IDLE; the result is dropped.
  - REQ without `dmem_resp` → DRAIN. Request masks stay held; DRAIN → IDLE on `dmem_resp`, with no CDB output.
  - REQ with `dmem_resp` the same cycle → IDLE.
  - `flush` in IDLE with `mem_pkt.valid`: the packet is not accepted.
- `flush` has priority over `cdb_grant` and over the WAIT_COMMIT head match.

## Configuration
- `MEM_FU_MISALIGN_CHK_EN` defined:
  - Half with ea[0]=1, or word with ea[1:0]!=0, skips REQ and goes directly to WB (loads and, after WAIT_COMMIT, stores).
  - WB then drives data=0 and `mem_misalign`=1.
  - No memory access is made.
- Undefined:
  - No check; the `mem_misalign` port is absent.
  - Misaligned masks shift out of range and are truncated to 4 bits.

## Test plan
- Reset: hold `rst`=0 with `mem_pkt.valid`=1 → `backpressure`=0, masks 0, `cdb_out.valid`=0. Release reset → accepted next edge.
- LB: rs1_v=0x1000, offset=3, mem_op=000, `dmem_rdata`=0x80FF_FF_FF with resp in the REQ cycle → `dmem_addr`=0x1000, rmask=4'b1000, `cdb_out.data`=0xFFFFFF80.
- SH: rs1_v=0x2002, rs2_v=0x1234, tag=7:
  - Head tag stays 3 for 4 cycles → rmask/wmask 0, stays in WAIT_COMMIT.
  - Head tag becomes 7 → wmask=4'b1100, wdata=0x12340000.
  - CDB data=0.
- WB stall: `cdb_grant`=0 for 3 cycles → `cdb_out` stable, `backpressure`=1; grant → IDLE next cycle.
- Flush in REQ with resp delayed 2 cycles → rmask held, no CDB valid, IDLE after resp, next packet accepted.
- With MEM_FU_MISALIGN_CHK_EN: LW ea=0x1001 → no request, `cdb_out.valid` at N+1 with `mem_misalign`=1, data=0.
